// File: rtl/iir_pkg.sv
// iir_pkg: shared filter-side constants and the stream driver state type
package iir_pkg;
  localparam int DATA_WIDTH = 24;
  typedef enum bit [1:0] {IDLE, RUN, DRAIN, DONE} driver_state_t;
endpackage

// File: rtl/iir_stream_driver_if.sv
// iir_stream_driver_if: x/y valid-ready streams between the driver (master) and the IIR filter (slave)
interface iir_stream_driver_if #(
  parameter int DATA_WIDTH = iir_pkg::DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] x;
  logic x_valid;
  logic x_ready_and;
  logic [DATA_WIDTH-1:0] y;
  logic y_valid;
  logic y_ready_and;
  modport master (output x, x_valid, y_ready_and, input x_ready_and, y, y_valid);
  modport slave (input x, x_valid, y_ready_and, output x_ready_and, y, y_valid);
endinterface

// File: rtl/iir_sample_fifo.sv
// iir_sample_fifo: flop-based sample FIFO with wrap-bit pointers and combinational head
module iir_sample_fifo #(
  parameter int DATA_WIDTH = iir_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic full,
  input  logic pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  always_comb begin
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    empty = wp == rp;
    head = mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= push_data;
        wp <= wp + (AW+1)'(1);
      end
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/iir_stream_driver.sv
// iir_stream_driver: feeds a frame of host samples into the IIR filter and collects its results
module iir_stream_driver
  import iir_pkg::*;
#(
  parameter int DATA_WIDTH = iir_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN = 16,
  localparam int CNT_WIDTH = $clog2(FRAME_LEN + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic sample_valid_i,
  output logic sample_ready_and_o,
  iir_stream_driver_if.master flt,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic result_valid_o,
  input  logic result_ready_and_i,
  output logic [CNT_WIDTH-1:0] sent_cnt_o,
  output logic [CNT_WIDTH-1:0] recv_cnt_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  driver_state_t state, state_nxt;
  logic full, empty, x_fire, y_fire, recv_ok, start_go;
  logic [CNT_WIDTH-1:0] sent_nxt, recv_nxt;
  iir_sample_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .push(sample_valid_i),
    .push_data(sample_i),
    .full(full),
    .pop(x_fire),
    .head(flt.x),
    .empty(empty)
  );
  always_comb begin
    sample_ready_and_o = !full;
    flt.x_valid = state == RUN && !empty;
    flt.y_ready_and = !result_valid_o || result_ready_and_i;
    x_fire = flt.x_valid && flt.x_ready_and;
    y_fire = flt.y_valid && flt.y_ready_and;
    recv_ok = (state == RUN || state == DRAIN) && recv_cnt_o < sent_cnt_o;
    start_go = state == IDLE && start_i;
    sent_nxt = start_go ? '0 : (x_fire && sent_cnt_o != LAST) ? sent_cnt_o + ONE : sent_cnt_o;
    recv_nxt = start_go ? '0 : (y_fire && recv_ok && recv_cnt_o != LAST) ? recv_cnt_o + ONE : recv_cnt_o;
    state_nxt = state == IDLE  ? (start_i ? RUN : IDLE) :
                state == RUN   ? (sent_nxt == LAST ? DRAIN : RUN) :
                state == DRAIN ? (recv_nxt == LAST ? DONE : DRAIN) : IDLE;
    busy_o = state == RUN || state == DRAIN;
    done_o = state == DONE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      sent_cnt_o <= '0;
      recv_cnt_o <= '0;
      result_o <= '0;
      result_valid_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      sent_cnt_o <= sent_nxt;
      recv_cnt_o <= recv_nxt;
      if (y_fire) result_o <= flt.y;
      result_valid_o <= y_fire || (result_valid_o && !result_ready_and_i);
      if (y_fire && !recv_ok) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_iir_stream_driver.sv
// tb_iir_stream_driver: scoreboard bench with a stalling filter model around iir_stream_driver
module tb_iir_stream_driver;
  localparam int DW = 24;
  localparam int CW = 3;
  logic clk = 0, reset_i = 1, start_i = 0, sample_valid_i = 0, hrdy = 1;
  logic [DW-1:0] sample_i = '0;
  logic sample_ready_and_o, result_valid_o, busy_o, done_o, err_o;
  logic [DW-1:0] result_o;
  logic [CW-1:0] sent_cnt_o, recv_cnt_o;
  logic x_rdy = 1, yv = 0;
  logic [DW-1:0] yd = '0, xs = '0;
  logic xh = 0, yh = 0, rs = 0, prev_yh = 0;
  int cd = 0, done_cnt = 0, n_chk = 0, n_pass = 0;
  logic [DW-1:0] exp_x[$], exp_r[$], fq[$];
  iir_stream_driver_if #(.DATA_WIDTH(DW)) fif ();
  assign fif.x_ready_and = x_rdy;
  assign fif.y_valid = yv;
  assign fif.y = yd;
  iir_stream_driver #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .FRAME_LEN(4)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .start_i(start_i),
    .sample_i(sample_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_and_o(sample_ready_and_o),
    .flt(fif),
    .result_o(result_o),
    .result_valid_o(result_valid_o),
    .result_ready_and_i(hrdy),
    .sent_cnt_o(sent_cnt_o),
    .recv_cnt_o(recv_cnt_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  always @(negedge clk) begin
    xh = !reset_i && fif.x_valid && x_rdy;
    xs = fif.x;
    yh = !reset_i && yv && fif.y_ready_and;
    rs = reset_i;
    if (xh) begin
      chk("x_expected", 32'(exp_x.size() > 0), 1);
      if (exp_x.size() > 0) chk("x_data", fif.x, exp_x.pop_front());
    end
    if (!reset_i && result_valid_o && hrdy) begin
      chk("result_expected", 32'(exp_r.size() > 0), 1);
      if (exp_r.size() > 0) chk("result_data", result_o, exp_r.pop_front());
    end
    if (done_o) begin
      done_cnt++;
      chk("done_after_capture", prev_yh, 1);
    end
    prev_yh = yh;
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rs) begin
      fq.delete();
      yv = 0;
      cd = 0;
      x_rdy = 1;
    end else begin
      if (xh) begin
        fq.push_back(xs + DW'(100));
        cd = 2;
      end else if (cd > 0) cd--;
      x_rdy = cd == 0;
      if (yh) yv = 0;
      if (!yv && fq.size() > 0) begin
        yv = 1;
        yd = fq.pop_front();
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic send(input logic [DW-1:0] v, input logic [DW-1:0] r);
    sample_valid_i = 1;
    sample_i = v;
    exp_x.push_back(v);
    exp_r.push_back(r);
    @(posedge clk);
    #1;
    sample_valid_i = 0;
  endtask
  task automatic start_frame();
    start_i = 1;
    @(posedge clk);
    #1;
    start_i = 0;
  endtask
  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done_o;
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
    chk("idle_after_done", busy_o, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle_reset();
    chk("rst_sample_ready", sample_ready_and_o, 1);
    chk("rst_result_valid", result_valid_o, 0);
    chk("rst_x_valid", fif.x_valid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_sent", sent_cnt_o, 0);
    chk("rst_recv", recv_cnt_o, 0);
  endtask
  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 0;
    chk_idle_reset();
    chk("rst_result", result_o, 0);
    send(1, 101);
    send(2, 102);
    send(3, 103);
    send(4, 104);
    chk("prefill_full", sample_ready_and_o, 0);
    chk("prefill_no_x", fif.x_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_x", fif.x_valid, 0);
    start_frame();
    wait_done();
    chk("f1_sent", sent_cnt_o, 4);
    chk("f1_recv", recv_cnt_o, 4);
    chk("f1_err", err_o, 0);
    chk("f1_result_drained", result_valid_o, 0);
    send(5, 105);
    send(6, 106);
    send(7, 107);
    send(8, 108);
    hrdy = 0;
    start_frame();
    sample_valid_i = 1;
    sample_i = 9;
    @(negedge clk);
    chk("push_refused_when_full", sample_ready_and_o, 0);
    chk("pop_while_full", fif.x_valid, 1);
    @(posedge clk);
    #1;
    sample_valid_i = 0;
    chk("one_slot_free", sample_ready_and_o, 1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = result_valid_o;
    end
    chk("hold_result_seen", ok, 1);
    chk("hold_y_ready_low", fif.y_ready_and, 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = yv && result_valid_o;
    end
    chk("hold_next_pending", ok, 1);
    chk("hold_y_ready_still_low", fif.y_ready_and, 0);
    chk("hold_result_kept", result_o, 105);
    @(posedge clk);
    #1;
    hrdy = 1;
    @(negedge clk);
    chk("release_y_ready", fif.y_ready_and, 1);
    @(posedge clk);
    #1;
    chk("no_bubble_valid", result_valid_o, 1);
    chk("no_bubble_data", result_o, 106);
    wait_done();
    chk("f2_sent", sent_cnt_o, 4);
    chk("f2_recv", recv_cnt_o, 4);
    @(negedge clk);
    fq.push_back(77);
    exp_r.push_back(77);
    repeat (6) @(posedge clk);
    #1;
    chk("idle_beat_err", err_o, 1);
    chk("idle_beat_recv_hold", recv_cnt_o, 4);
    chk("idle_beat_busy", busy_o, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_sticky", err_o, 1);
    send(11, 111);
    send(12, 112);
    send(13, 113);
    send(14, 114);
    start_frame();
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = sent_cnt_o == 2;
    end
    chk("mid_frame_two_sent", ok, 1);
    @(posedge clk);
    #1;
    reset_i = 1;
    @(posedge clk);
    #1;
    reset_i = 0;
    exp_x.delete();
    exp_r.delete();
    chk_idle_reset();
    send(21, 121);
    send(22, 122);
    send(23, 123);
    send(24, 124);
    start_frame();
    wait_done();
    chk("f4_sent", sent_cnt_o, 4);
    chk("f4_recv", recv_cnt_o, 4);
    chk("f4_err", err_o, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("x_queue_empty", exp_x.size(), 0);
    chk("result_queue_empty", exp_r.size(), 0);
    chk("done_pulses", done_cnt, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
